// File: rtl/wb_buffer.sv
// Write-back buffer: DEPTH-entry FIFO of {addr,data} draining into a 1R/1W register file port.
// Latency: writes drain in push order when no read is accepted; rd_valid one cycle after read accept.
// Backpressure: in_ready drops when full; rd_ready drops when full (and on address hazard unless WB_BUFFER_BYPASS_EN).
module wb_buffer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q, rd_valid_d;

  logic              full, match, rd_fire, push, pop;
  logic [PTR_W-1:0]  idx;

`ifdef WB_BUFFER_BYPASS_EN
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] byp_q, byp_d;
  logic [DATA_W-1:0] match_data;
`endif

  // Scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef WB_BUFFER_BYPASS_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
        match = 1'b1;
`ifdef WB_BUFFER_BYPASS_EN
        match_data = data_q[idx];
`endif
      end
    end
  end

  // Handshakes and register-file port arbitration; reset forces the idle view.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    in_ready = rst | ~full;
`ifdef WB_BUFFER_BYPASS_EN
    rd_ready = rst | ~full;
`else
    rd_ready = rst | (~full & ~match);
`endif
    rd_fire  = rd_req & rd_ready & ~rst;
    push     = in_valid & in_ready & ~rst;
    pop      = ~rd_fire & (count_q != '0) & ~rst;
    rf_addr  = '0;
    rf_d_in  = '0;
    rf_we_   = 1'b1;
    if (rd_fire) begin
      rf_addr = rd_addr;
    end else if (pop) begin
      rf_addr = addr_q[head_q];
      rf_d_in = data_q[head_q];
      rf_we_  = 1'b0;
    end
  end

  // Next-state for FIFO storage, pointers, occupancy and read response.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_valid_d = rd_fire;
    if (push) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

`ifdef WB_BUFFER_BYPASS_EN
  // Capture forwarded data at read acceptance; the read never sees a same-cycle push.
  always_comb begin
    hit_d = hit_q;
    byp_d = byp_q;
    if (rd_fire) begin
      hit_d = match;
      byp_d = match_data;
    end
  end
`endif

  // State registers with synchronous reset; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
`ifdef WB_BUFFER_BYPASS_EN
      hit_q      <= 1'b0;
      byp_q      <= '0;
`endif
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
`ifdef WB_BUFFER_BYPASS_EN
      hit_q      <= hit_d;
      byp_q      <= byp_d;
`endif
    end
  end

  // Read response; a read in flight when reset asserts is suppressed.
  always_comb begin
    rd_valid = rd_valid_q & ~rst;
    rd_data  = '0;
    if (rd_valid) begin
`ifdef WB_BUFFER_BYPASS_EN
      rd_data = hit_q ? byp_q : rf_d_out;
`else
      rd_data = rf_d_out;
`endif
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer with a behavioural register file model.
// Covers reset view, single drain, full/backpressure, hazard/forwarding, reset mid-drain.
// Build with or without WB_BUFFER_BYPASS_EN; expectations follow the macro.
module tb_wb_buffer;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rd_req, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;
  logic          rf_we_;
  logic [DW-1:0] rf_d_out = '0;
  logic [DW-1:0] rf_mem [32] = '{default: '0};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rf_addr(rf_addr), .rf_d_in(rf_d_in), .rf_we_(rf_we_), .rf_d_out(rf_d_out)
  );

  // Register file: synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    if (!rf_we_) rf_mem[rf_addr] <= rf_d_in;
    rf_d_out <= rf_mem[rf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; rd_req = 1'b0; rd_addr = '0;

    // Reset view
    tick(); #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rf_we_", 32'(rf_we_), 1);
    chk("rst_rf_addr", 32'(rf_addr), 0);
    chk("rst_rd_data", rd_data, 0);
    tick(); rst = 1'b0; #1;
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_rd_ready", 32'(rd_ready), 1);
    chk("idle_rf_we_", 32'(rf_we_), 1);
    chk("idle_rf_addr", 32'(rf_addr), 0);
    chk("idle_rf_d_in", rf_d_in, 0);
    chk("idle_rd_valid", 32'(rd_valid), 0);

    // Single push drains next cycle
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h33; #1;
    chk("p3_in_ready", 32'(in_ready), 1);
    chk("p3_empty_no_we", 32'(rf_we_), 1);
    tick(); in_valid = 1'b0; #1;
    chk("p3_we", 32'(rf_we_), 0);
    chk("p3_rf_addr", 32'(rf_addr), 3);
    chk("p3_rf_d_in", rf_d_in, 32'h33);
    tick(); #1;
    chk("p3_after_we", 32'(rf_we_), 1);
    chk("p3_after_addr", 32'(rf_addr), 0);
    chk("p3_after_din", rf_d_in, 0);
    // Read it back from the register file
    rd_req = 1'b1; rd_addr = 5'd3; #1;
    chk("r3_rd_ready", 32'(rd_ready), 1);
    chk("r3_rf_addr", 32'(rf_addr), 3);
    tick(); rd_req = 1'b0; rd_addr = '0; #1;
    chk("r3_rd_valid", 32'(rd_valid), 1);
    chk("r3_rd_data", rd_data, 32'h33);
    tick(); #1;
    chk("r3_valid_drop", 32'(rd_valid), 0);
    chk("r3_data_zero", rd_data, 0);

    // Held reads block drain; fill to full
    rd_req = 1'b1; rd_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(8 + i); in_data = 32'h100 + 32'(i); #1;
      chk("fill_in_ready", 32'(in_ready), 1);
      chk("fill_rd_ready", 32'(rd_ready), 1);
      chk("fill_no_we", 32'(rf_we_), 1);
      if (i > 0) chk("fill_rd_valid", 32'(rd_valid), 1);
      tick();
    end
    in_valid = 1'b1; in_addr = 5'd12; in_data = 32'h104; #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_rd_ready", 32'(rd_ready), 0);
    chk("full_we", 32'(rf_we_), 0);
    chk("full_rf_addr", 32'(rf_addr), 8);
    chk("full_rf_d_in", rf_d_in, 32'h100);
    tick(); #1;
    chk("unfull_in_ready", 32'(in_ready), 1);
    chk("unfull_rd_ready", 32'(rd_ready), 1);
    chk("unfull_read_cycle", 32'(rf_we_), 1);
    chk("unfull_rd_valid", 32'(rd_valid), 0);
    tick(); in_valid = 1'b0; rd_req = 1'b0; #1;
    chk("drain_rd_valid", 32'(rd_valid), 1);
    for (int j = 0; j < 4; j++) begin
      chk("drain_we", 32'(rf_we_), 0);
      chk("drain_addr", 32'(rf_addr), 32'(9 + j));
      chk("drain_d_in", rf_d_in, 32'h101 + 32'(j));
      tick(); #1;
    end
    chk("drain_done", 32'(rf_we_), 1);

    // Duplicate address 7: forwarding or hazard stall
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA; rd_req = 1'b1; rd_addr = 5'd7; #1;
    chk("a7_rd_ready", 32'(rd_ready), 1);
    tick(); in_data = 32'hB; rd_addr = 5'd1; #1;
    chk("same_cycle_push_invisible_v", 32'(rd_valid), 1);
    chk("same_cycle_push_invisible_d", rd_data, 0);
    tick(); in_valid = 1'b0; rd_addr = 5'd7; #1;
`ifdef WB_BUFFER_BYPASS_EN
    chk("byp_rd_ready", 32'(rd_ready), 1);
    tick(); rd_req = 1'b0; #1;
    chk("byp_rd_valid", 32'(rd_valid), 1);
    chk("byp_rd_data", rd_data, 32'hB);
    chk("byp_drain_a", rf_d_in, 32'hA);
    tick(); #1;
    chk("byp_drain_b", rf_d_in, 32'hB);
    tick(); #1;
    chk("byp_idle", 32'(rf_we_), 1);
`else
    chk("haz_rd_ready0", 32'(rd_ready), 0);
    chk("haz_drain_a", rf_d_in, 32'hA);
    tick(); #1;
    chk("haz_rd_ready1", 32'(rd_ready), 0);
    chk("haz_drain_b", rf_d_in, 32'hB);
    chk("haz_no_valid", 32'(rd_valid), 0);
    tick(); #1;
    chk("haz_rd_ready2", 32'(rd_ready), 1);
    chk("haz_read_cycle", 32'(rf_we_), 1);
    tick(); rd_req = 1'b0; #1;
    chk("haz_rd_valid", 32'(rd_valid), 1);
    chk("haz_rd_data", rd_data, 32'hB);
`endif

    // Reset in mid-drain with a read in flight
    rd_req = 1'b1; rd_addr = 5'd2;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_addr = 5'(20 + k); in_data = 32'h200 + 32'(k); #1;
      chk("rfill_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0; rd_req = 1'b0; #1;
    chk("rdrain_we", 32'(rf_we_), 0);
    chk("rdrain_addr", 32'(rf_addr), 20);
    tick(); rd_req = 1'b1; #1;
    chk("rinflight_ready", 32'(rd_ready), 1);
    tick(); rst = 1'b1; rd_req = 1'b0; in_valid = 1'b1; in_addr = 5'd21; in_data = 32'h99; #1;
    chk("rmid_rd_valid", 32'(rd_valid), 0);
    chk("rmid_rd_data", rd_data, 0);
    chk("rmid_we", 32'(rf_we_), 1);
    chk("rmid_rf_addr", 32'(rf_addr), 0);
    chk("rmid_in_ready", 32'(in_ready), 1);
    tick(); rst = 1'b0; in_valid = 1'b0; #1;
    chk("rpost_we", 32'(rf_we_), 1);
    chk("rpost_in_ready", 32'(in_ready), 1);
    chk("rpost_rd_ready", 32'(rd_ready), 1);
    chk("rpost_rd_valid", 32'(rd_valid), 0);
    tick(); #1;
    chk("rpost_no_drain", 32'(rf_we_), 1);
    rd_req = 1'b1; rd_addr = 5'd21;
    tick(); rd_addr = 5'd20; #1;
    chk("r21_valid", 32'(rd_valid), 1);
    chk("r21_discarded", rd_data, 0);
    tick(); rd_req = 1'b0; #1;
    chk("r20_b2b_valid", 32'(rd_valid), 1);
    chk("r20_data", rd_data, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter ADDR_W, default 5, register address width.
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter DEPTH, default 4, pending-write entries (power of two, >=2).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream write-back request.
REQ-007 in_ready  out  1  buffer accepts request this cycle.
REQ-008 in_addr  in  ADDR_W  write-back register address.
REQ-009 in_data  in  DATA_W  write-back data.
REQ-010 rd_req  in  1  read request.
REQ-011 rd_ready  out  1  read accepted this cycle.
REQ-012 rd_addr  in  ADDR_W  read address.
REQ-013 rd_valid  out  1  rd_data valid, one cycle after acceptance.
REQ-014 rd_data  out  DATA_W  read result.
REQ-015 rf_addr  out  ADDR_W  register file address.
REQ-016 rf_d_in  out  DATA_W  register file write data.
REQ-017 rf_we_  out  1  register file write enable, active-low.
REQ-018 rf_d_out  in  DATA_W  register file read data, valid one cycle after address.

Function
REQ-019 Circular FIFO, DEPTH entries of {addr,data}; head/tail pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-020 Push on in_valid & in_ready; in_ready = (count < DEPTH); full FIFO never overwrites.
REQ-021 Per-cycle port arbitration: read cycle if rd_req & rd_ready; else write cycle if count > 0; else idle.
REQ-022 Read cycle: rf_addr = rd_addr, rf_we_ = 1, rf_d_in = 0.
REQ-023 Write cycle: rf_addr/rf_d_in = head entry, rf_we_ = 0, head popped at same edge.
REQ-024 Idle: rf_addr = 0, rf_d_in = 0, rf_we_ = 1.
REQ-025 rf_* outputs combinational from state and rd_req/rd_addr.
REQ-026 rd_ready = 0 when count == DEPTH (full FIFO forces a write cycle; no read starvation of drain).
REQ-027 rd_valid = 1 exactly one cycle after each accepted read; back-to-back reads give back-to-back rd_valid.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 Push in same cycle as accepted read to same address: not visible to that read.
REQ-030 In-order drain: entries written to register file in push order; duplicate addresses all written, youngest last.
REQ-031 rd_data = 0 whenever rd_valid = 0.

Reset
REQ-032 rst = 1 at rising edge: count = 0, head = tail = 0, rd_valid = 0, bypass latch cleared; pending writes discarded.
REQ-033 During and after reset until next push/read: in_ready = 1, rd_ready = 1, rf_we_ = 1, rf_addr = 0, rf_d_in = 0, rd_data = 0.
REQ-034 Request accepted in the reset cycle is dropped; read in flight at reset produces no rd_valid.

Configuration
REQ-035 Macro WB_BUFFER_BYPASS_EN selects read forwarding.
REQ-036 Defined: on read acceptance, youngest FIFO entry matching rd_addr is latched; next cycle rd_data = latched data if matched, else rf_d_out; rd_ready independent of address hazards.
REQ-037 Undefined: rd_ready additionally 0 while any FIFO entry matches rd_addr; rd_data = rf_d_out; no forwarding logic present.

Verification
REQ-038 rst 2 cycles, then idle -> in_ready=1, rd_ready=1, rf_we_=1, rf_addr=0, rd_valid=0.
REQ-039 Push addr 3 data 0x33, no reads -> next cycle rf_we_=0, rf_addr=3, rf_d_in=0x33; following cycle count=0, idle outputs.
REQ-040 Hold rd_req (addr 0) while pushing 5 writes -> 4 accepted, 5th sees in_ready=0; rd_ready=0 while full; write cycle drains one entry, then in_ready=1.
REQ-041 With bypass: push addr 7 data 0xA, then addr 7 data 0xB, read addr 7 before drain -> rd_valid next cycle, rd_data=0xB.
REQ-042 Without bypass: same stimulus -> rd_ready=0 until both addr-7 writes drained; then read returns rf_d_out=0xB.
REQ-043 Push 3 entries, assert rst mid-drain -> no further rf_we_=0 cycles, count=0, in_ready=1 after reset.
